// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the switchable ALU domain: orders drain,
// isolate and power-cut on the way down and power, reset release and de-isolate on the way up.
module alu_pwr_seq #(
  parameter int unsigned ISO_SETUP  = 2,
  parameter int unsigned PWR_SETTLE = 8,
  parameter int unsigned RST_HOLD   = 2,
  parameter int unsigned DRAIN_MAX  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pu_req,
  input  logic       pd_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_rst_n,
  output logic       pwr_ready,
  output logic       pwr_off,
  output logic       pd_err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_UNRST   = 3'd2,
    ST_ON      = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_ISOLATE = 3'd5
  } state_e;

  // A timed state exits on the cycle its counter reaches the last count.
  localparam logic [7:0] ISO_LAST   = 8'(ISO_SETUP - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(PWR_SETTLE - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(RST_HOLD - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pd_err_d;
  logic       pwr_en_q, iso_q, dom_rst_n_q, ready_q, off_q, pd_err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cnt_d    = '0;
    pd_err_d = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pu_req) state_d = ST_PWRUP;
      end
      ST_PWRUP: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_UNRST;
        else                      cnt_d   = cnt_q + 8'd1;
      end
      ST_UNRST: begin
        if (cnt_q == HOLD_LAST) state_d = ST_ON;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      ST_ON: begin
        if (pd_req && !pu_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pu_req) begin
          state_d = ST_ON;
        end else if (!alu_busy) begin
          state_d = ST_ISOLATE;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d  = ST_ON;
          pd_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ISOLATE: begin
        // Power was never removed, so an abort goes straight back to ON.
        if (pu_req)                  state_d = ST_ON;
        else if (cnt_q == ISO_LAST)  state_d = ST_OFF;
        else                         cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: async reset forces the domain off at once; isolation rises as power drops.
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      pwr_en_q    <= 1'b0;
      iso_q       <= 1'b1;
      dom_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      off_q       <= 1'b1;
      pd_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwr_en_q    <= (state_d != ST_OFF);
      iso_q       <= !((state_d == ST_ON) || (state_d == ST_DRAIN));
      dom_rst_n_q <= !((state_d == ST_OFF) || (state_d == ST_PWRUP));
      ready_q     <= (state_d == ST_ON);
      off_q       <= (state_d == ST_OFF);
      pd_err_q    <= pd_err_d;
    end
  end

  assign alu_pwr_en = pwr_en_q;
  assign iso_en     = iso_q;
  assign alu_rst_n  = dom_rst_n_q;
  assign pwr_ready  = ready_q;
  assign pwr_off    = off_q;
  assign pd_err     = pd_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Directed bench for alu_pwr_seq: power-up/down sequences, drain timeout,
// aborts and mid-sequence reset, plus a monitor for the isolation/reset ordering rules.
module tb_alu_pwr_seq;

  localparam int ISO_SETUP = 2;
  localparam int RST_HOLD  = 2;

  localparam logic [2:0] S_OFF = 3'd0, S_PWRUP = 3'd1, S_UNRST = 3'd2,
                         S_ON  = 3'd3, S_DRAIN = 3'd4, S_ISO   = 3'd5;

  logic       clk, rst_n, pu_req, pd_req, alu_busy;
  logic       alu_pwr_en, iso_en, alu_rst_n, pwr_ready, pwr_off, pd_err;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  alu_pwr_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pu_req     (pu_req),
    .pd_req     (pd_req),
    .alu_busy   (alu_busy),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .alu_rst_n  (alu_rst_n),
    .pwr_ready  (pwr_ready),
    .pwr_off    (pwr_off),
    .pd_err     (pd_err),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected {state, pwr_en, iso, rst_n, ready, off, pd_err} for a state.
  function automatic logic [8:0] expected(input logic [2:0] st, input logic err);
    logic pwr, iso, rn;
    case (st)
      S_OFF:   {pwr, iso, rn} = 3'b010;
      S_PWRUP: {pwr, iso, rn} = 3'b110;
      S_UNRST: {pwr, iso, rn} = 3'b111;
      S_ON:    {pwr, iso, rn} = 3'b101;
      S_DRAIN: {pwr, iso, rn} = 3'b101;
      default: {pwr, iso, rn} = 3'b111;
    endcase
    return {st, pwr, iso, rn, st == S_ON, st == S_OFF, err};
  endfunction

  task automatic expect_st(input string tag, input logic [2:0] st, input logic err = 1'b0);
    check(tag, 32'({state_o, alu_pwr_en, iso_en, alu_rst_n, pwr_ready, pwr_off, pd_err}),
          32'(expected(st, err)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requires pu_req high and the block in OFF; walks the full power-up.
  task automatic power_up(input string tag);
    pu_req = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick();
      expect_st($sformatf("%s_e%0d", tag, e),
                (e <= 8) ? S_PWRUP : (e <= 10) ? S_UNRST : S_ON);
    end
    pu_req = 1'b0;
  endtask

  // Ordering monitor: power may only drop after ISO_SETUP isolated samples,
  // isolation may only drop with the domain out of reset for RST_HOLD samples.
  logic prev_pwr = 1'b0, prev_iso = 1'b1;
  int   iso_run = 0, rst_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pwr = 1'b0;
      prev_iso = 1'b1;
      iso_run  = 0;
      rst_run  = 0;
    end else begin
      if (prev_pwr && !alu_pwr_en)
        check("inv_iso_before_pwr_off", 32'(iso_run >= ISO_SETUP), 32'd1);
      if (prev_iso && !iso_en) begin
        check("inv_rst_released_at_deiso", 32'(alu_rst_n), 32'd1);
        check("inv_rst_hold_before_deiso", 32'(rst_run >= RST_HOLD), 32'd1);
      end
      iso_run  = iso_en    ? iso_run + 1 : 0;
      rst_run  = alu_rst_n ? rst_run + 1 : 0;
      prev_pwr = alu_pwr_en;
      prev_iso = iso_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    pu_req   = 1'b0;
    pd_req   = 1'b0;
    alu_busy = 1'b0;
    repeat (3) tick();
    expect_st("in_reset", S_OFF);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_st($sformatf("idle_%0d", i), S_OFF);
    end

    power_up("pu1");
    tick();
    expect_st("on_hold", S_ON);

    // Power-down with busy for 5 DRAIN cycles, pd_req kept high throughout.
    pd_req   = 1'b1;
    alu_busy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_st($sformatf("drain_busy_%0d", i), S_DRAIN);
    end
    alu_busy = 1'b0;
    tick(); expect_st("iso_1", S_ISO);
    tick(); expect_st("iso_2", S_ISO);
    tick(); expect_st("pd_off", S_OFF);
    tick(); expect_st("off_ignores_pd", S_OFF);
    pd_req = 1'b0;

    power_up("pu2");

    // Drain timeout: busy stuck high.
    pd_req   = 1'b1;
    alu_busy = 1'b1;
    tick(); expect_st("to_drain_1", S_DRAIN);
    pd_req = 1'b0;
    for (int i = 2; i <= 64; i++) begin
      tick();
      expect_st($sformatf("to_drain_%0d", i), S_DRAIN);
    end
    tick(); expect_st("to_back_on_err", S_ON, 1'b1);
    tick(); expect_st("to_err_cleared", S_ON);
    alu_busy = 1'b0;

    // Abort from ISOLATE.
    pd_req = 1'b1;
    tick(); expect_st("ab_drain", S_DRAIN);
    tick(); expect_st("ab_iso", S_ISO);
    pd_req = 1'b0;
    pu_req = 1'b1;
    tick(); expect_st("ab_on", S_ON);
    pu_req = 1'b0;

    // Both requests in ON: power-up wins.
    pu_req = 1'b1;
    pd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_st($sformatf("both_on_%0d", i), S_ON);
    end
    pu_req = 1'b0;
    tick(); expect_st("pd_after_both", S_DRAIN);
    tick(); expect_st("pd_after_both_iso1", S_ISO);
    pd_req = 1'b0;
    tick(); expect_st("pd_after_both_iso2", S_ISO);
    tick(); expect_st("pd_after_both_off", S_OFF);

    // Reset during PWRUP cycle 4.
    pu_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_st($sformatf("rst_pwrup_%0d", i), S_PWRUP);
    end
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("rst_async_off", S_OFF);
    pu_req = 1'b0;
    tick(); expect_st("rst_held", S_OFF);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_st($sformatf("post_rst_idle_%0d", i), S_OFF);
    end
    pu_req = 1'b1;
    tick(); expect_st("post_rst_pwrup", S_PWRUP);
    pu_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
